// File: rtl/cpu_oam_dma_pkg.sv
// Shared constants and state encoding for the CPU sprite (OAM) DMA engine.
package cpu_oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

endpackage

// File: rtl/cpu_oam_dma.sv
// CPU-driven OAM DMA: a write to the DMA register halts the CPU and copies
// one 256-byte page into the PPU OAMDATA port, one read/write pair per two
// CPU cycles. Reads always land on get cycles, writes on put cycles.
module cpu_oam_dma
  import cpu_oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic [15:0] dec_addr,
  input  logic        dec_addr_valid,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_stall,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata
);

  dma_state_t  state, state_next;
  logic [7:0]  idx;
  logic [7:0]  page;
  logic [7:0]  latch;
  logic        parity;

  logic        trigger;
  logic        load_page;
  logic        capture;
  logic        advance;

  // Register-space write to the exact DMA address; folded mirrors do not match.
  assign trigger = cpu_wr && !dec_addr_valid && (dec_addr == DMA_REG_ADDR);

  // State register; only moves on CPU cycle enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes for the transfer sequencer.
  always_comb begin
    state_next = state;
    load_page  = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    if (cpu_ce) begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state_next = ST_HALT;
            load_page  = 1'b1;
          end
        end
        // parity holds the current cycle; the next cycle is a get cycle
        // exactly when the current one is a put cycle.
        ST_HALT:  state_next = parity ? ST_READ : ST_ALIGN;
        ST_ALIGN: state_next = ST_READ;
        ST_READ: begin
          capture    = 1'b1;
          state_next = ST_WRITE;
        end
        ST_WRITE: begin
          advance    = 1'b1;
          state_next = (idx == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Page, byte index, data latch and get/put parity tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      page   <= '0;
      latch  <= '0;
      parity <= 1'b0;
    end else if (cpu_ce) begin
      parity <= ~parity;
      if (load_page) page  <= cpu_wdata;
      if (capture)   latch <= bus_rdata;
      if (advance)   idx   <= idx + 8'd1;
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    cpu_stall = (state != ST_IDLE);
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      ST_READ: begin
        bus_rd   = 1'b1;
        bus_addr = {page, idx};
      end
      ST_WRITE: begin
        bus_wr    = 1'b1;
        bus_addr  = OAM_DATA_ADDR;
        bus_wdata = latch;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Scoreboard bench for cpu_oam_dma: stimulus pushes the expected bus
// transactions of each page copy; a monitor pops them as the DUT presents them.
module tb_cpu_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce;
  logic [15:0] dec_addr;
  logic        dec_addr_valid;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_stall;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_wdata;

  always #5 clk = ~clk;

  cpu_oam_dma #(
    .DMA_REG_ADDR  (16'h4014),
    .OAM_DATA_ADDR (16'h2004)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_ce         (cpu_ce),
    .dec_addr       (dec_addr),
    .dec_addr_valid (dec_addr_valid),
    .cpu_wr         (cpu_wr),
    .cpu_wdata      (cpu_wdata),
    .bus_rdata      (bus_rdata),
    .cpu_stall      (cpu_stall),
    .bus_addr       (bus_addr),
    .bus_rd         (bus_rd),
    .bus_wr         (bus_wr),
    .bus_wdata      (bus_wdata)
  );

  // Memory model answering DMA reads.
  logic [7:0] mem [0:65535];
  assign bus_rdata = mem[bus_addr];

  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_e;
  int    tests = 0;
  int    fails = 0;
  int    stall_cnt = 0;
  int    pre_cnt = 0;
  bit    tb_par = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every CPU cycle either carries the next expected transaction or is quiet.
  always @(negedge clk) begin
    if (rst_n && cpu_ce) begin
      if (cpu_stall) stall_cnt++;
      if (bus_rd || bus_wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bus", {14'b0, bus_rd, bus_wr, bus_addr}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check(mon_e.is_wr ? "oam_write" : "page_read",
                {6'b0, bus_rd, bus_wr, bus_addr, bus_wdata},
                {6'b0, ~mon_e.is_wr, mon_e.is_wr, mon_e.addr,
                 mon_e.is_wr ? mon_e.data : 8'h00});
        end
      end else begin
        if (cpu_stall) pre_cnt++;
        check("quiet_outputs", {8'b0, bus_addr, bus_wdata}, 32'h0);
      end
    end
  end

  // One CPU cycle: a single-clock cpu_ce pulse, then 0-2 clocks of gap with
  // write-like junk on the bus that must be ignored because cpu_ce is low.
  task automatic cpu_cycle(input logic wr, input logic [15:0] addr, input logic valid,
                           input logic [7:0] data);
    cpu_ce         = 1'b1;
    cpu_wr         = wr;
    dec_addr       = addr;
    dec_addr_valid = valid;
    cpu_wdata      = data;
    @(posedge clk); #1;
    tb_par         = ~tb_par;
    cpu_ce         = 1'b0;
    cpu_wr         = 1'($urandom_range(0, 1));
    dec_addr       = 16'h4014;
    dec_addr_valid = 1'b0;
    cpu_wdata      = 8'($urandom);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic idle_cycle();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    cpu_cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic push_page(input logic [7:0] page);
    logic [15:0] a;
    for (int i = 0; i < 256; i++) begin
      a = {page, 8'(i)};
      exp_q.push_back('{is_wr: 1'b0, addr: a, data: 8'h00});
      exp_q.push_back('{is_wr: 1'b1, addr: 16'h2004, data: mem[a]});
    end
  endtask

  // cpu_ce held low for 10 clocks while a read is presented.
  task automatic hold_check();
    logic [15:0] ea;
    ea = (exp_q.size() > 0) ? exp_q[0].addr : 16'hxxxx;
    cpu_ce = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("pause_hold", {6'b0, cpu_stall, bus_rd, bus_wr, bus_addr, bus_wdata[6:0]},
            {6'b0, 1'b1, 1'b1, 1'b0, ea, 7'h00});
    end
  endtask

  task automatic run_dma(input logic [7:0] page, input bit want_par, input bit retrig,
                         input bit pause);
    int exp_stall;
    int exp_pre;
    bit done;
    bit paused;
    done   = 1'b0;
    paused = 1'b0;
    if (tb_par != want_par) idle_cycle();
    push_page(page);
    exp_stall = tb_par ? 514 : 513;
    exp_pre   = tb_par ? 2 : 1;
    stall_cnt = 0;
    pre_cnt   = 0;
    cpu_cycle(1'b1, 16'h4014, 1'b0, page);
    for (int n = 0; n < 1200; n++) begin
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      if (pause && !paused && bus_rd && n > 20) begin
        hold_check();
        paused = 1'b1;
      end
      if (retrig && (n == 50 || n == 51)) cpu_cycle(1'b1, 16'h4014, 1'b0, ~page);
      else idle_cycle();
    end
    check("transfer_ends", {31'b0, done}, 32'd1);
    check("stall_cycles", stall_cnt, exp_stall);
    check("halt_align_cycles", pre_cnt, exp_pre);
    check("transfers_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) idle_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    rst_n          = 1'b0;
    cpu_ce         = 1'b0;
    cpu_wr         = 1'b0;
    dec_addr       = '0;
    dec_addr_valid = 1'b0;
    cpu_wdata      = '0;
    #1;
    check("reset_outputs", {5'b0, cpu_stall, bus_rd, bus_wr, bus_addr, bus_wdata}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tb_par = 1'b0;
    @(posedge clk); #1;

    // Near-miss writes must not start a transfer.
    cpu_cycle(1'b1, 16'h4014, 1'b1, 8'h02);
    check("no_trig_mem_space", {31'b0, cpu_stall}, 32'd0);
    cpu_cycle(1'b1, 16'h2004, 1'b0, 8'h02);
    check("no_trig_oamdata", {31'b0, cpu_stall}, 32'd0);
    cpu_cycle(1'b1, 16'h2014, 1'b0, 8'h02);
    check("no_trig_mirror", {31'b0, cpu_stall}, 32'd0);
    cpu_cycle(1'b0, 16'h4014, 1'b0, 8'h02);
    check("no_trig_read", {31'b0, cpu_stall}, 32'd0);
    repeat (4) idle_cycle();

    run_dma(8'h02, 1'b0, 1'b0, 1'b0);
    run_dma(8'h02, 1'b1, 1'b0, 1'b0);
    run_dma(8'hFF, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_dma(8'h10, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    run_dma(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // Reset in the middle of a page copy.
    found = 1'b0;
    push_page(8'h05);
    cpu_cycle(1'b1, 16'h4014, 1'b0, 8'h05);
    for (int n = 0; n < 1200; n++) begin
      if (bus_rd && bus_addr == 16'h0540) begin
        found = 1'b1;
        break;
      end
      idle_cycle();
    end
    check("reached_idx_40", {31'b0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {5'b0, cpu_stall, bus_rd, bus_wr, bus_addr, bus_wdata}, 32'h0);
    exp_q.delete();
    tb_par = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dma(8'h03, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
